// File: rtl/bus_arb.sv
// bus_arb: registered KS10 bus arbiter. A single owner (console, one of NUBA
// UBAs, or the CPU) is latched at grant and held through BUSY -> ACK -> RELEASE.
// Same-priority UBAs are served round-robin. An unanswered cycle ends by
// timeout with a non-existent-device flag.
module bus_arb #(
  parameter int NUBA    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU requester
  input  logic                 cpuREQI,
  output logic                 cpuACKO,
  output logic                 cpuNXMO,
  input  logic [35:0]          cpuADDRI,
  input  logic [35:0]          cpuDATAI,
  output logic [35:0]          cpuDATAO,
  // console requester / target
  input  logic                 cslREQI,
  output logic                 cslACKO,
  output logic                 cslNXMO,
  input  logic [35:0]          cslADDRI,
  input  logic [35:0]          cslDATAI,
  output logic [35:0]          cslDATAO,
  output logic                 cslREQO,
  input  logic                 cslACKI,
  // UBA requesters / targets, UBA k at bits 36k+35..36k
  input  logic [NUBA-1:0]      ubaREQI,
  output logic [NUBA-1:0]      ubaACKO,
  output logic [NUBA-1:0]      ubaNXMO,
  input  logic [36*NUBA-1:0]   ubaADDRI,
  input  logic [36*NUBA-1:0]   ubaDATAI,
  input  logic [NUBA-1:0]      ubaACKI,
  input  logic [36*NUBA-1:0]   ubaRDATAI,
  output logic                 ubaREQO,
  output logic [35:0]          ubaDATAO,
  // memory target
  output logic                 memREQO,
  input  logic                 memACKI,
  input  logic [35:0]          memDATAI,
  output logic [35:0]          memDATAO,
  output logic [35:0]          arbADDRO
);

  localparam int UW = (NUBA > 1) ? $clog2(NUBA) : 1;

  localparam logic [1:0] stIDLE    = 2'd0;
  localparam logic [1:0] stBUSY    = 2'd1;
  localparam logic [1:0] stACK     = 2'd2;
  localparam logic [1:0] stRELEASE = 2'd3;

  localparam logic [1:0] ownCPU = 2'd0;
  localparam logic [1:0] ownCSL = 2'd1;
  localparam logic [1:0] ownUBA = 2'd2;

  // VMA flags: PDP-10 bit n lives at vector bit 35-n
  localparam int vmaPHYSICAL = 35 - 8;
  localparam int vmaIOCYCLE  = 35 - 10;
  localparam int vmaWRUCYCLE = 35 - 11;

  logic [1:0]    state;
  logic [1:0]    ownType;
  logic [UW-1:0] ownUba;
  logic [UW-1:0] rrPtr;
  logic [9:0]    toCnt;
  logic          nxmFlag;

  logic          rrHit;
  logic [UW-1:0] rrSel;
  logic [35:0]   rrAddr;
  logic [35:0]   rrData;
  logic          ackHit;
  logic [35:0]   ackData;
  logic          ownReq;
  logic          isWru;

  assign isWru = (ownType == ownCPU) && arbADDRO[vmaPHYSICAL] &&
                 arbADDRO[vmaIOCYCLE] && arbADDRO[vmaWRUCYCLE];

  // Round-robin pick: first requesting UBA at or above the pointer, else wrap
  always_comb begin
    rrHit  = 1'b0;
    rrSel  = '0;
    rrAddr = '0;
    rrData = '0;
    for (int k = 0; k < NUBA; k++)
      if (!rrHit && ubaREQI[k] && (k >= int'(rrPtr))) begin
        rrHit = 1'b1;
        rrSel = UW'(k);
      end
    for (int k = 0; k < NUBA; k++)
      if (!rrHit && ubaREQI[k]) begin
        rrHit = 1'b1;
        rrSel = UW'(k);
      end
    for (int k = 0; k < NUBA; k++)
      if (rrSel == UW'(k)) begin
        rrAddr = ubaADDRI[36*k +: 36];
        rrData = ubaDATAI[36*k +: 36];
      end
  end

  // Ack select: memory, then UBAs by index (never the owner itself), then console
  always_comb begin
    ackHit  = 1'b0;
    ackData = '0;
    if (memACKI) begin
      ackHit  = 1'b1;
      ackData = memDATAI;
    end
    for (int k = 0; k < NUBA; k++)
      if (!ackHit && ubaACKI[k] && !((ownType == ownUBA) && (ownUba == UW'(k)))) begin
        ackHit  = 1'b1;
        ackData = ubaRDATAI[36*k +: 36];
      end
    if (!ackHit && cslACKI && (ownType == ownCPU)) begin
      ackHit  = 1'b1;
      ackData = cslDATAI;
    end
  end

  // Owner's own request line, watched in RELEASE
  always_comb begin
    ownReq = cpuREQI;
    if (ownType == ownCSL) ownReq = cslREQI;
    if (ownType == ownUBA)
      for (int k = 0; k < NUBA; k++)
        if (ownUba == UW'(k)) ownReq = ubaREQI[k];
  end

  // Per-UBA ack/NXM pulses during ACK
  always_comb begin
    ubaACKO = '0;
    ubaNXMO = '0;
    for (int k = 0; k < NUBA; k++)
      if ((state == stACK) && (ownType == ownUBA) && (ownUba == UW'(k))) begin
        ubaACKO[k] = 1'b1;
        ubaNXMO[k] = nxmFlag;
      end
  end

  assign memREQO = (state == stBUSY);
  assign ubaREQO = (state == stBUSY) && (ownType != ownUBA);
  assign cslREQO = (state == stBUSY) && (ownType == ownCPU);
  assign cpuACKO = (state == stACK) && (ownType == ownCPU);
  assign cpuNXMO = cpuACKO && nxmFlag;
  assign cslACKO = (state == stACK) && (ownType == ownCSL);
  assign cslNXMO = cslACKO && nxmFlag;

  // Arbiter FSM with grant latching, ack capture and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= stIDLE;
      ownType  <= ownCPU;
      ownUba   <= '0;
      rrPtr    <= '0;
      toCnt    <= '0;
      nxmFlag  <= 1'b0;
      arbADDRO <= '0;
      memDATAO <= '0;
      ubaDATAO <= '0;
      cslDATAO <= '0;
      cpuDATAO <= '0;
    end else begin
      case (state)
        stIDLE: begin
          if (cslREQI || rrHit || cpuREQI) begin
            state   <= stBUSY;
            toCnt   <= '0;
            nxmFlag <= 1'b0;
            if (cslREQI) begin
              ownType  <= ownCSL;
              arbADDRO <= cslADDRI;
              memDATAO <= cslDATAI;
              ubaDATAO <= cslDATAI;
              cslDATAO <= cslDATAI;
            end else if (rrHit) begin
              ownType  <= ownUBA;
              ownUba   <= rrSel;
              arbADDRO <= rrAddr;
              memDATAO <= rrData;
              ubaDATAO <= rrData;
              rrPtr    <= (int'(rrSel) == NUBA - 1) ? '0 : rrSel + UW'(1);
            end else begin
              ownType  <= ownCPU;
              arbADDRO <= cpuADDRI;
              memDATAO <= cpuDATAI;
              ubaDATAO <= cpuDATAI;
              cslDATAO <= cpuDATAI;
            end
          end
        end
        stBUSY: begin
          toCnt <= toCnt + 10'd1;
          // ack beats WRU and timeout; WRU ends after the 2nd BUSY cycle
          if (ackHit || (isWru && toCnt == 10'd1) || (toCnt == 10'(TIMEOUT - 1))) begin
            state   <= stACK;
            nxmFlag <= !ackHit && !isWru;
            case (ownType)
              ownCSL:  cslDATAO <= ackHit ? ackData : '0;
              ownUBA:  ubaDATAO <= ackHit ? ackData : '0;
              default: cpuDATAO <= ackHit ? ackData : '0;
            endcase
          end
        end
        stACK:   state <= stRELEASE;
        default: if (!ownReq) state <= stIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: scoreboard bench for bus_arb. Expected completions are queued
// when requests are raised and checked against each ACKO pulse.
module tb_bus_arb;
  localparam int NUBA    = 3;
  localparam int TIMEOUT = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic                cpuREQI, cpuACKO, cpuNXMO;
  logic [35:0]         cpuADDRI, cpuDATAI, cpuDATAO;
  logic                cslREQI, cslACKO, cslNXMO, cslREQO, cslACKI;
  logic [35:0]         cslADDRI, cslDATAI, cslDATAO;
  logic [NUBA-1:0]     ubaREQI, ubaACKO, ubaNXMO, ubaACKI;
  logic [36*NUBA-1:0]  ubaADDRI, ubaDATAI, ubaRDATAI;
  logic                ubaREQO;
  logic [35:0]         ubaDATAO;
  logic                memREQO, memACKI;
  logic [35:0]         memDATAI, memDATAO, arbADDRO;

  bus_arb #(.NUBA(NUBA), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpuREQI(cpuREQI), .cpuACKO(cpuACKO), .cpuNXMO(cpuNXMO),
    .cpuADDRI(cpuADDRI), .cpuDATAI(cpuDATAI), .cpuDATAO(cpuDATAO),
    .cslREQI(cslREQI), .cslACKO(cslACKO), .cslNXMO(cslNXMO),
    .cslADDRI(cslADDRI), .cslDATAI(cslDATAI), .cslDATAO(cslDATAO),
    .cslREQO(cslREQO), .cslACKI(cslACKI),
    .ubaREQI(ubaREQI), .ubaACKO(ubaACKO), .ubaNXMO(ubaNXMO),
    .ubaADDRI(ubaADDRI), .ubaDATAI(ubaDATAI), .ubaACKI(ubaACKI),
    .ubaRDATAI(ubaRDATAI), .ubaREQO(ubaREQO), .ubaDATAO(ubaDATAO),
    .memREQO(memREQO), .memACKI(memACKI), .memDATAI(memDATAI),
    .memDATAO(memDATAO), .arbADDRO(arbADDRO)
  );

  always #5 clk = ~clk;

  int nChk  = 0;
  int nFail = 0;

  task automatic chkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          who;   // 0 cpu, 1 console, 2+k UBA k
    logic [35:0] addr;
    logic [35:0] data;
    logic        nxm;
  } exp_t;
  exp_t sbq[$];

  task automatic sbPush(input int who, input logic [35:0] addr, input logic [35:0] data, input logic nxm);
    exp_t e;
    e.who = who; e.addr = addr; e.data = data; e.nxm = nxm;
    sbq.push_back(e);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory responder, requester agents and ack monitor (all at negedge)
  int memLat = 0;
  int memRun = 0, lastRun = 0, busyStart = 0, ackCyc = 0, ackTotal = 0;
  int rearm[NUBA];
  int reqLeft[NUBA];

  initial begin
    for (int k = 0; k < NUBA; k++) begin rearm[k] = 0; reqLeft[k] = 0; end
    forever begin
      @(negedge clk);
      if (memREQO) begin
        memRun++;
        if (memRun == 1) busyStart = cyc;
        memACKI = (memLat != 0) && (memRun == memLat);
      end else begin
        if (memRun != 0) lastRun = memRun;
        memRun  = 0;
        memACKI = 1'b0;
      end
      if (cpuACKO || cslACKO || (ubaACKO != '0)) begin
        int who;
        logic [35:0] obsData;
        logic obsNxm;
        exp_t e;
        ackCyc = cyc;
        ackTotal++;
        who = 0; obsData = cpuDATAO; obsNxm = cpuNXMO;
        if (cslACKO) begin who = 1; obsData = cslDATAO; obsNxm = cslNXMO; end
        for (int k = 0; k < NUBA; k++)
          if (ubaACKO[k]) begin who = 2 + k; obsData = ubaDATAO; obsNxm = ubaNXMO[k]; end
        chkVal("single_owner_ack", 64'(int'(cpuACKO) + int'(cslACKO) + $countones(ubaACKO)), 64'd1);
        if (sbq.size() == 0) chkVal("sb_unexpected_ack", 64'(sbq.size()), 64'd1);
        else begin
          e = sbq.pop_front();
          chkVal("sb_owner", 64'(who), 64'(e.who));
          chkVal("sb_addr", 64'(arbADDRO), 64'(e.addr));
          chkVal("sb_data", 64'(obsData), 64'(e.data));
          chkVal("sb_nxm", 64'(obsNxm), 64'(e.nxm));
        end
      end
      if (cpuACKO) cpuREQI = 1'b0;
      if (cslACKO) cslREQI = 1'b0;
      for (int k = 0; k < NUBA; k++) begin
        if (ubaACKO[k]) begin
          ubaREQI[k] = 1'b0;
          rearm[k]   = 2;
        end else if (rearm[k] != 0) begin
          rearm[k]--;
          if (rearm[k] == 0 && reqLeft[k] > 0) begin
            ubaREQI[k] = 1'b1;
            reqLeft[k]--;
          end
        end
      end
    end
  end

  task automatic waitAcks(input int n, input int budget, input string tag);
    int t = 0;
    while (ackTotal < n && t < budget) begin @(posedge clk); t++; end
    chkVal(tag, 64'(ackTotal), 64'(n));
    repeat (3) @(posedge clk);
    #1;
  endtask

  localparam logic [35:0] PHYS = 36'd1 << (35 - 8);
  localparam logic [35:0] IOC  = 36'd1 << (35 - 10);
  localparam logic [35:0] WRU  = 36'd1 << (35 - 11);

  initial begin
    int base;
    int t;
    rst = 1'b1;
    cpuREQI = 0; cpuADDRI = '0; cpuDATAI = '0;
    cslREQI = 0; cslADDRI = '0; cslDATAI = '0; cslACKI = 0;
    ubaREQI = '0; ubaADDRI = '0; ubaDATAI = '0; ubaACKI = '0; ubaRDATAI = '0;
    memACKI = 0; memDATAI = '0;
    repeat (3) @(posedge clk);
    #1;
    chkVal("rst_reqo", 64'({memREQO, ubaREQO, cslREQO}), 64'd0);
    chkVal("rst_acko_nxmo", 64'({cpuACKO, cslACKO, ubaACKO, cpuNXMO, cslNXMO, ubaNXMO}), 64'd0);
    chkVal("rst_datao", 64'(cpuDATAO | cslDATAO | ubaDATAO | memDATAO), 64'd0);
    chkVal("rst_addr", 64'(arbADDRO), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CPU read, memory acks in 3rd BUSY cycle
    memLat = 3; memDATAI = 36'o123456701234;
    cpuADDRI = 36'o000000_001000;
    sbPush(0, cpuADDRI, 36'o123456701234, 1'b0);
    cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 1, 40, "cpu_read_done");
    chkVal("cpu_read_memreq_cycles", 64'(lastRun), 64'd3);
    chkVal("cpu_read_ack_latency", 64'(ackCyc - busyStart), 64'd3);
    chkVal("cpu_read_datao_hold", 64'(cpuDATAO), 64'(36'o123456701234));

    // round robin over 3 UBAs, uba0/uba1 request twice, uba2 once
    memLat = 1; memDATAI = 36'o707070707070;
    for (int k = 0; k < NUBA; k++) ubaADDRI[36*k +: 36] = 36'o100 + 36'(k);
    reqLeft[0] = 1; reqLeft[1] = 1; reqLeft[2] = 0;
    sbPush(2, 36'o100, 36'o707070707070, 1'b0);
    sbPush(3, 36'o101, 36'o707070707070, 1'b0);
    sbPush(4, 36'o102, 36'o707070707070, 1'b0);
    sbPush(2, 36'o100, 36'o707070707070, 1'b0);
    sbPush(3, 36'o101, 36'o707070707070, 1'b0);
    ubaREQI = 3'b111;
    base = ackTotal; waitAcks(base + 5, 120, "rr_done");

    // console > UBA > CPU on simultaneous requests
    memDATAI = 36'o000000000777;
    cslADDRI = 36'o200; cslDATAI = 36'o11;
    ubaADDRI[0 +: 36] = 36'o300;
    cpuADDRI = 36'o400; cpuDATAI = 36'o33;
    sbPush(1, 36'o200, 36'o777, 1'b0);
    sbPush(2, 36'o300, 36'o777, 1'b0);
    sbPush(0, 36'o400, 36'o777, 1'b0);
    cslREQI = 1'b1; ubaREQI[0] = 1'b1; cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 3, 60, "prio_done");

    // CPU write to unmapped I/O: timeout with NXM
    memLat = 0;
    cpuADDRI = PHYS | IOC | 36'o777000; cpuDATAI = 36'o525252525252;
    sbPush(0, cpuADDRI, 36'd0, 1'b1);
    cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 1, TIMEOUT + 20, "timeout_done");
    chkVal("timeout_latency", 64'(ackCyc - busyStart), 64'(TIMEOUT));
    chkVal("timeout_wrdata_mem", 64'(memDATAO), 64'(36'o525252525252));
    chkVal("timeout_wrdata_uba", 64'(ubaDATAO), 64'(36'o525252525252));

    // WRU cycle: early completion, data 0, no NXM
    cpuADDRI = PHYS | IOC | WRU;
    sbPush(0, cpuADDRI, 36'd0, 1'b0);
    cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 1, 30, "wru_done");
    chkVal("wru_latency", 64'(ackCyc - busyStart), 64'd2);

    // simultaneous acks: mem beats UBA2 and console
    cpuADDRI = 36'o1000;
    memLat = 1; memDATAI = 36'o111111111111;
    ubaRDATAI[72 +: 36] = 36'o222222222222; ubaACKI = 3'b100; cslACKI = 1'b1;
    sbPush(0, cpuADDRI, 36'o111111111111, 1'b0);
    cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 1, 30, "ackprio_mem_done");
    // without memory, UBA2 beats console
    memLat = 0;
    sbPush(0, cpuADDRI, 36'o222222222222, 1'b0);
    cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 1, 30, "ackprio_uba_done");

    // UBA1 owner ignores its own ack and console ack: timeout NXM
    ubaACKI = 3'b010; cslACKI = 1'b1;
    ubaADDRI[36 +: 36] = 36'o500;
    sbPush(3, 36'o500, 36'd0, 1'b1);
    ubaREQI[1] = 1'b1;
    base = ackTotal; waitAcks(base + 1, TIMEOUT + 20, "own_ack_ignored_done");
    chkVal("own_ack_latency", 64'(ackCyc - busyStart), 64'(TIMEOUT));
    ubaACKI = '0; cslACKI = 1'b0;

    // ack in the same cycle as timeout: ack wins, no NXM
    memLat = TIMEOUT; memDATAI = 36'o444444444444;
    cpuADDRI = 36'o2000;
    sbPush(0, cpuADDRI, 36'o444444444444, 1'b0);
    cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 1, TIMEOUT + 20, "ack_vs_timeout_done");
    chkVal("ack_vs_timeout_latency", 64'(ackCyc - busyStart), 64'(TIMEOUT));

    // reset in BUSY abandons the cycle
    memLat = 0;
    cpuADDRI = 36'o3000;
    cpuREQI = 1'b1;
    t = 0;
    while (!memREQO && t < 20) begin @(posedge clk); #1; t++; end
    chkVal("rst_busy_reached", 64'(memREQO), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chkVal("rst_busy_memreq", 64'(memREQO), 64'd0);
    chkVal("rst_busy_acko", 64'(cpuACKO), 64'd0);
    chkVal("rst_busy_datao", 64'(cpuDATAO), 64'd0);
    rst = 1'b0; cpuREQI = 1'b0;
    repeat (2) @(posedge clk); #1;
    memLat = 2; memDATAI = 36'o666000666000;
    sbPush(0, cpuADDRI, 36'o666000666000, 1'b0);
    cpuREQI = 1'b1;
    base = ackTotal; waitAcks(base + 1, 30, "post_rst_done");
    chkVal("post_rst_latency", 64'(ackCyc - busyStart), 64'd2);

    chkVal("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
